// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit: state encoding, opcodes,
// halt marker and the absolute branch/jump target table.
package fetch_unit_pkg;

  localparam int PC_W  = 10;
  localparam int TBL_N = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_J   = 3'b100;
  localparam logic [2:0] OP_BEQ = 3'b101;

  // A jump to this operand is the halt instruction.
  localparam logic [5:0] HALT_OPERAND = 6'h3F;

  typedef logic [TBL_N-1:0][PC_W-1:0] target_tbl_t;

  // Mostly a stride-20 table, with a few hand-placed targets (low code,
  // the top of the address space) used by boot code.
  function automatic target_tbl_t build_targets();
    target_tbl_t t;
    for (int i = 0; i < TBL_N; i++) t[i] = PC_W'(i * 20);
    t[3] = PC_W'(100);
    t[4] = PC_W'(10);
    t[5] = PC_W'(1023);
    t[6] = PC_W'(50);
    return t;
  endfunction

  localparam target_tbl_t TARGET_TABLE = build_targets();

endpackage

// File: rtl/target_lut.sv
// Combinational operand -> absolute target address lookup.
module target_lut #(
  parameter int PC_W = 10
) (
  input  logic [5:0]      idx,
  output logic [PC_W-1:0] target
);
  import fetch_unit_pkg::*;

  assign target = PC_W'(TARGET_TABLE[idx]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns pc and the IDLE/RUN/HALT sequencer, splits the
// fetched word into opcode/operand and counts RUN cycles.
module fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr_rdata,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         opcode,
  output logic [5:0]         operand,
  output logic               instr_valid,
  output logic               done,
  output logic [15:0]        cycle_count
);
  import fetch_unit_pkg::*;

  state_t          state, state_nxt;
  logic            is_halt;
  logic            take_target;
  logic [PC_W-1:0] target;
  logic [15:0]     count_inc;

  assign opcode  = instr_rdata[8:6];
  assign operand = instr_rdata[5:0];

  assign is_halt     = (opcode == OP_J) && (operand == HALT_OPERAND);
  assign take_target = jump || (branch && zero);
  assign count_inc   = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;

  target_lut #(.PC_W(PC_W)) u_target_lut (
    .idx    (operand),
    .target (target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (!start && is_halt) state_nxt = HALT;
      HALT:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_valid = (state == RUN);
  end

  // start wins over everything; the halt cycle itself still counts as a RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (start) begin
            pc          <= '0;
            cycle_count <= '0;
          end else if (is_halt) begin
            done        <= 1'b1;
            cycle_count <= count_inc;
          end else begin
            pc          <= take_target ? target : pc + PC_W'(1);
            cycle_count <= count_inc;
          end
        end
        IDLE, HALT: begin
          if (start) begin
            pc          <= '0;
            done        <= 1'b0;
            cycle_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Vector-table bench for fetch_unit with a scoreboard queue of expected
// post-edge state plus hand-written halt-hold and mid-RUN reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, branch, jump, zero;
  logic [8:0]  instr_rdata;
  logic [9:0]  pc;
  logic [2:0]  opcode;
  logic [5:0]  operand;
  logic        instr_valid, done;
  logic [15:0] cycle_count;

  fetch_unit #(.PC_W(10), .INSTR_W(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instr_rdata (instr_rdata),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .pc          (pc),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, jump, branch, zero;
    logic [8:0] instr;
    int         pc;
    logic       done, valid;
    int         cc;
  } vec_t;

  vec_t sbq[$];
  vec_t va[16];
  vec_t vb[5];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic s, logic j, logic b, logic z, logic [8:0] ins,
                              int epc, logic edone, logic evld, int ecc);
    vec_t v;
    v.start = s; v.jump = j; v.branch = b; v.zero = z; v.instr = ins;
    v.pc = epc; v.done = edone; v.valid = evld; v.cc = ecc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called just after a falling edge: drive, check decode, clock once, check state.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    start = v.start; jump = v.jump; branch = v.branch; zero = v.zero;
    instr_rdata = v.instr;
    #1;
    check({tag, ".opcode"},  32'(opcode),  32'(v.instr[8:6]));
    check({tag, ".operand"}, 32'(operand), 32'(v.instr[5:0]));
    sbq.push_back(v);
    @(posedge clk);
    @(negedge clk);
    if (sbq.size() == 0) begin
      check({tag, ".sbq_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({tag, ".pc"},          32'(pc),          32'(e.pc));
      check({tag, ".done"},        32'(done),        32'(e.done));
      check({tag, ".instr_valid"}, 32'(instr_valid), 32'(e.valid));
      check({tag, ".cycle_count"}, 32'(cycle_count), 32'(e.cc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // start/jump/branch/zero/instr -> pc/done/valid/cycle_count after the edge
    va[0]  = mk(1, 0, 0, 0, 9'b000_000000,   0, 0, 1,  0);
    for (int i = 1; i <= 7; i++)
      va[i] = mk(0, 0, 0, 0, 9'b000_000000, i, 0, 1, i);
    va[8]  = mk(0, 1, 0, 0, 9'b100_000010,  40, 0, 1,  8);
    va[9]  = mk(0, 1, 0, 0, 9'b100_000100,  10, 0, 1,  9);
    va[10] = mk(0, 0, 0, 0, 9'b000_000000,  11, 0, 1, 10);
    va[11] = mk(0, 0, 0, 0, 9'b000_000000,  12, 0, 1, 11);
    va[12] = mk(0, 0, 1, 0, 9'b101_000011,  13, 0, 1, 12);
    va[13] = mk(0, 0, 1, 1, 9'b101_000011, 100, 0, 1, 13);
    va[14] = mk(0, 1, 0, 0, 9'b100_000001,  20, 0, 1, 14);
    va[15] = mk(0, 1, 0, 0, 9'b100_111111,  20, 1, 0, 15);

    vb[0]  = mk(1, 0, 0, 0, 9'b000_000000,    0, 0, 1, 0);
    vb[1]  = mk(0, 1, 0, 0, 9'b100_000101, 1023, 0, 1, 1);
    vb[2]  = mk(0, 0, 0, 0, 9'b000_000000,    0, 0, 1, 2);
    vb[3]  = mk(1, 1, 0, 0, 9'b100_000010,    0, 0, 1, 0);
    vb[4]  = mk(0, 1, 0, 0, 9'b100_000110,   50, 0, 1, 1);

    rst_n = 1'b0; start = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    instr_rdata = '0;
    @(negedge clk);
    check("rst.pc",          32'(pc),          32'd0);
    check("rst.done",        32'(done),        32'd0);
    check("rst.instr_valid", 32'(instr_valid), 32'd0);
    check("rst.cycle_count", 32'(cycle_count), 32'd0);
    rst_n = 1'b1;

    // Control flags while IDLE must not move pc.
    run_vec(mk(0, 1, 1, 1, 9'b100_000010, 0, 0, 0, 0), "idle_ignore");

    for (int i = 0; i < 16; i++) run_vec(va[i], $sformatf("va%0d", i));

    // Halted: pc/done/count hold for 10 cycles, decoder flags ignored.
    for (int i = 0; i < 10; i++)
      run_vec(mk(0, 1, 1, 1, 9'b100_000011, 20, 1, 0, 15), $sformatf("halt_hold%0d", i));

    for (int i = 0; i < 5; i++) run_vec(vb[i], $sformatf("vb%0d", i));

    // Asynchronous reset mid-RUN at pc=50, checked before the next rising edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.pc",          32'(pc),          32'd0);
    check("async_rst.instr_valid", 32'(instr_valid), 32'd0);
    check("async_rst.done",        32'(done),        32'd0);
    check("async_rst.cycle_count", 32'(cycle_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(0, 1, 0, 0, 9'b100_000110, 0, 0, 0, 0), "post_rst_idle");
    run_vec(mk(1, 0, 0, 0, 9'b000_000000, 0, 0, 1, 0), "post_rst_start");
    run_vec(mk(0, 0, 0, 0, 9'b000_000000, 1, 0, 1, 1), "post_rst_seq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10: program counter width in bits.
REQ-002 SHALL have parameter INSTR_W, default 9: instruction width in bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: level-sampled request to begin execution at address 0.
REQ-006 SHALL have port instr_rdata, input, INSTR_W: instruction memory read data, combinational from pc.
REQ-007 SHALL have port branch, input, 1: conditional-branch flag from the control decoder.
REQ-008 SHALL have port jump, input, 1: unconditional-jump flag from the control decoder.
REQ-009 SHALL have port zero, input, 1: ALU equality flag, valid in the same cycle as branch.
REQ-010 SHALL have port pc, output, PC_W: current instruction address to instruction memory.
REQ-011 SHALL have port opcode, output, 3: instr_rdata[8:6], feeding the control decoder.
REQ-012 SHALL have port operand, output, 6: instr_rdata[5:0].
REQ-013 SHALL have port instr_valid, output, 1: high only in RUN; gates register and memory writes downstream.
REQ-014 SHALL have port done, output, 1: high while in HALT.
REQ-015 SHALL have port cycle_count, output, 16: number of RUN cycles since the last start.

Function
REQ-016 SHALL implement states IDLE, RUN and HALT.
REQ-017 SHALL transition IDLE->RUN when start=1, loading pc=0 and cycle_count=0.
REQ-018 SHALL, in RUN with start=0, compute next pc with priority: halt, then jump, then taken branch, then sequential.
REQ-019 SHALL detect halt when opcode=3'b100 and operand=6'h3F: go to HALT, hold pc, set done on the next edge.
REQ-020 SHALL, on jump=1 (non-halt), load pc=target_lut(operand).
REQ-021 SHALL, on branch=1 and zero=1, load pc=target_lut(operand); branch=1 with zero=0 gives pc+1.
REQ-022 SHALL compute the sequential pc as pc+1 modulo 2^PC_W, so 1023 wraps to 0 with no flag.
REQ-023 SHALL restart in RUN when start=1: pc=0, cycle_count=0; this takes priority over all RUN updates.
REQ-024 SHALL transition HALT->RUN on start=1, with pc=0, cycle_count=0 and done=0 on the next edge.
REQ-025 SHALL hold pc, done and cycle_count in HALT while start=0.
REQ-026 SHALL increment cycle_count once per RUN cycle, saturating at 16'hFFFF.
REQ-027 SHALL drive opcode and operand combinationally from instr_rdata in every state, adding zero latency.
REQ-028 SHALL assert instr_valid combinationally from state==RUN.
REQ-029 SHALL ignore branch, jump and zero outside RUN.

Reset
REQ-030 SHALL, on rst_n=0 and independent of clk, force state=IDLE, pc=0, done=0 and cycle_count=0.
REQ-031 SHALL abandon any in-flight execution when reset is asserted mid-RUN; no pending target is retained.
REQ-032 SHALL require a start after reset release before any pc change.

Structure
REQ-033 SHALL place the following in a shared package: state enum, opcode constants (including OP_J=3'b100), HALT_OPERAND=6'h3F, PC_W and the 64-entry target table.
REQ-034 SHALL use one sub-module, target_lut: combinational, 6-bit index in, PC_W-bit absolute address out, contents from the package table.
REQ-035 SHALL keep the pc and state registers in fetch_unit only.

Verification
REQ-036 SHALL cover: reset, then start pulse, with 5 cycles of opcode=000 -> pc 0,1,2,3,4,5; cycle_count=5; instr_valid=1.
REQ-037 SHALL cover: pc=7, jump=1, operand=2, target_lut[2]=40 -> pc=40 next cycle.
REQ-038 SHALL cover: branch=1 with zero=0 at pc=12 -> pc=13; branch=1 with zero=1, target_lut[3]=100 -> pc=100.
REQ-039 SHALL cover: instr_rdata=9'b100_111111 at pc=20 -> HALT, done=1, pc stays 20 for 10 cycles; a start pulse then gives pc=0, done=0.
REQ-040 SHALL cover: pc=1023 with a sequential instruction -> pc=0; rst_n low mid-RUN at pc=50 -> immediately pc=0, IDLE, instr_valid=0.
